alu_control_mdu: RTL and testbench

- Next-generation ALU control for the pipelined CPU's EX stage.
- Decodes ALUOp_i/funct_i into ALUCtrl_o exactly as the current generation does.
- Adds a parametrised iterative multiplier sequencer for MUL, which stalls the pipeline until the product is ready.
- Sits between the ID/EX pipeline register, the ALU, and the hazard/stall logic.

---
 rtl/alu_control_mdu.sv | 112 +++++++++++
 tb/tb_alu_control_mdu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: EX-stage ALU control decode plus an iterative MUL sequencer that stalls until the product is ready.
// Define ALU_CONTROL_MDU_MUL_HI_EN to add mul_hi_o, the high half of the unsigned 2*DATA_W product.
module alu_control_mdu #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        funct_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [2:0]        ALUCtrl_o,
  output logic              is_mul_o,
  output logic              stall_o,
  output logic              mul_valid_o,
  output logic [DATA_W-1:0] mul_result_o
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
  ,
  output logic [DATA_W-1:0] mul_hi_o
`endif
);
  localparam int N_ITER = DATA_W / BITS_PER_CYCLE;
  localparam int CW = N_ITER > 1 ? $clog2(N_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
  localparam int AW = 2 * DATA_W;
`else
  localparam int AW = DATA_W;
`endif

  if (DATA_W % BITS_PER_CYCLE != 0) begin : g_chk
    $error("DATA_W must be a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic [AW-1:0]       mcand_q, acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q, res_q;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          f;
  logic [2:0]          r_ctrl;
  logic                start;
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
  logic [DATA_W-1:0]   hi_q;
  assign mul_hi_o = hi_q;
`endif

  // Zero-latency decode of the ALU op class and R-type funct field
  always_comb begin
    f = funct_i[3:0];
    r_ctrl = f == 4'b0000 ? 3'b010 :
             f == 4'b0010 ? 3'b110 :
             f == 4'b0100 ? 3'b000 :
             f == 4'b0101 ? 3'b001 :
             f == 4'b1010 ? 3'b111 :
             f == 4'b1000 ? 3'b011 : 3'b000;
    ALUCtrl_o = ALUOp_i == 2'b11 ? r_ctrl :
                ALUOp_i == 2'b00 ? 3'b010 :
                ALUOp_i == 2'b01 ? 3'b110 : 3'b001;
  end

  assign is_mul_o     = ALUOp_i == 2'b11 && funct_i[3:0] == 4'b1000;
  assign start        = state_q == IDLE && valid_i && is_mul_o && !flush_i;
  assign stall_o      = !rst_i && !flush_i && (start || state_q == BUSY);
  assign mul_valid_o  = state_q == DONE && !flush_i;
  assign mul_result_o = res_q;
  assign acc_d        = acc_q + mcand_q * AW'(mplier_q[BITS_PER_CYCLE-1:0]);

  // Multiply sequencer: capture operands, retire BITS_PER_CYCLE multiplier bits per BUSY cycle, publish in DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
      hi_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_q  <= AW'(a_i);
          mplier_q <= b_i;
          acc_q    <= '0;
          cnt_q    <= '0;
          state_q  <= BUSY;
        end
        BUSY: if (flush_i) state_q <= IDLE;
        else begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            res_q   <= acc_d[DATA_W-1:0];
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
            hi_q    <= acc_d[AW-1:DATA_W];
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_control_mdu.sv
// tb_alu_control_mdu: randomized self-checking bench for alu_control_mdu against a cycle-level reference model.
module tb_alu_control_mdu;
  localparam int W = 32;
  localparam int B = 8;
  localparam int N = W / B;

  logic clk = 1'b0;
  logic rst, valid, flush, is_mul, stall, mul_valid;
  logic [5:0] funct;
  logic [1:0] alu_op;
  logic [W-1:0] a, b, mul_result;
  logic [2:0] alu_ctrl;
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
  logic [W-1:0] mul_hi;
`endif

  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_res = '0;
  logic [W-1:0] exp_hi = '0;

  always #5 clk = ~clk;

  alu_control_mdu #(.DATA_W(W), .BITS_PER_CYCLE(B)) dut (
    .clk_i(clk), .rst_i(rst), .funct_i(funct), .ALUOp_i(alu_op),
    .valid_i(valid), .flush_i(flush), .a_i(a), .b_i(b),
    .ALUCtrl_o(alu_ctrl), .is_mul_o(is_mul), .stall_o(stall),
    .mul_valid_o(mul_valid), .mul_result_o(mul_result)
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
    , .mul_hi_o(mul_hi)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_dec(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b10) return 3'b001;
    case (fn[3:0])
      4'b0000: return 3'b010;
      4'b0010: return 3'b110;
      4'b0100: return 3'b000;
      4'b0101: return 3'b001;
      4'b1010: return 3'b111;
      4'b1000: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    check(tag, mul_result, exp_res);
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
    check({tag, "_hi"}, mul_hi, exp_hi);
`endif
  endtask

  task automatic idle();
    valid = 1'b0;
    flush = 1'b0;
    #3;
    check("idle_stall", stall, 0);
    check("idle_valid", mul_valid, 0);
    check_held("idle_res");
    cyc();
  endtask

  // Issue one MUL in the current cycle; valid stays high through DONE unless flushed at cycle flush_at.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int flush_at);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    for (int k = 0; k <= N + 1; k++) begin
      valid = 1'b1;
      alu_op = 2'b11;
      funct = 6'b011000;
      flush = (k == flush_at);
      if (k == 0) begin a = x; b = y; end
      else begin a = $urandom; b = $urandom; end
      #3;
      if (k == flush_at) begin
        check("flush_stall", stall, 0);
        check("flush_valid", mul_valid, 0);
        cyc();
        valid = 1'b0;
        flush = 1'b0;
        for (int j = 0; j <= N + 1; j++) begin
          #3;
          check("post_flush_stall", stall, 0);
          check("post_flush_valid", mul_valid, 0);
          check_held("post_flush_res");
          cyc();
        end
        return;
      end
      if (k <= N) begin
        check("busy_stall", stall, 1);
        check("busy_valid", mul_valid, 0);
        check_held("busy_res");
      end else begin
        exp_res = p[31:0];
        exp_hi = p[63:32];
        check("done_stall", stall, 0);
        check("done_valid", mul_valid, 1);
        check_held("done_res");
      end
      cyc();
    end
  endtask

  initial begin
    logic [1:0] ops [10] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [5:0] fns [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b011000, 6'b000000, 6'b000000, 6'b000000, 6'b000111};
    logic [2:0] exps [10] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b010, 3'b110, 3'b001, 3'b000};
    logic [2:0] e;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; funct = '0; alu_op = '0; a = '0; b = '0;
    cyc();
    cyc();
    check("rst_stall", stall, 0);
    check("rst_valid", mul_valid, 0);
    check_held("rst_res");
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 10; i++) begin
      alu_op = ops[i];
      funct = fns[i];
      valid = exps[i] != 3'b011;
      #3;
      check("sweep_ctrl", alu_ctrl, exps[i]);
      check("sweep_is_mul", is_mul, exps[i] == 3'b011);
      check("sweep_stall", stall, 0);
      cyc();
    end

    for (int i = 0; i < 40; i++) begin
      alu_op = 2'($urandom);
      funct = 6'($urandom);
      e = ref_dec(alu_op, funct);
      valid = !(alu_op == 2'b11 && funct[3:0] == 4'b1000);
      #3;
      check("rand_ctrl", alu_ctrl, e);
      check("rand_is_mul", is_mul, !valid);
      check("rand_stall", stall, 0);
      cyc();
    end

    do_mul(32'h00001234, 32'h00005678, -1);
    check("mul_1234", mul_result, 32'h06260060);
    idle();

    do_mul(32'hFFFFFFFF, 32'h00000002, -1);
    check("mul_ovf", mul_result, 32'hFFFFFFFE);
`ifdef ALU_CONTROL_MDU_MUL_HI_EN
    check("mul_ovf_hi", mul_hi, 32'h00000001);
`endif
    idle();

    do_mul($urandom, $urandom, 2);
    idle();

    do_mul($urandom, $urandom, -1);
    do_mul(32'd7, 32'd6, -1);
    check("mul_7x6", mul_result, 32'h0000002A);
    idle();

    for (int i = 0; i < 40; i++) begin
      do_mul($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 255)) : $urandom, $urandom,
             $urandom_range(0, 3) == 0 ? int'($urandom_range(0, N)) : -1);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    valid = 1'b1; alu_op = 2'b11; funct = 6'b011000; a = $urandom; b = $urandom;
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    exp_res = '0;
    exp_hi = '0;
    check("arst_stall", stall, 0);
    check("arst_valid", mul_valid, 0);
    check_held("arst_res");
    valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    do_mul($urandom, $urandom, -1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
